alu_nibble_seq: RTL and testbench

//  Multi-cycle sequencer wrapping the 4-bit combinational ALU: runs W-bit (4*NIB) operations one nibble per cycle, LSB first.

---
 rtl/alu_nibble_seq_if.sv | 29 ++
 rtl/alu_nibble_seq.sv | 110 +++++++++++
 tb/tb_alu_nibble_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_nibble_seq_if.sv
// Controller-side handshake and operand/result bundle for the nibble-serial ALU sequencer.
interface alu_nibble_seq_if #(
  parameter int NIB = 2
);
  localparam int W = 4 * NIB;

  logic         start;
  logic [1:0]   op;
  logic         l;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         sign;
  logic         busy;
  logic         done;

  modport master (
    output start, op, l, cin, a, b,
    input  result, carry, zero, sign, busy, done
  );

  modport slave (
    input  start, op, l, cin, a, b,
    output result, carry, zero, sign, busy, done
  );
endinterface

// File: rtl/alu_nibble_seq.sv
// Runs W-bit operations through a 4-bit combinational ALU one nibble per cycle, LSB first,
// rippling the carry between passes and assembling result and flags.
module alu_nibble_seq #(
  parameter int NIB = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_nibble_seq_if.slave      ctl,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic                 alu_c_in,
  output logic [1:0]           alu_op,
  output logic                 alu_l,
  input  logic [3:0]           alu_r,
  input  logic                 alu_c_out,
  input  logic                 alu_zero,
  input  logic                 alu_sign
);
  localparam int W  = 4 * NIB;
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, next;
  logic [IW-1:0] idx;
  logic [1:0]    op_q;
  logic          l_q;
  logic          cin_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  result_q;
  logic          carry_q;
  logic          zero_q;
  logic          sign_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (ctl.start) next = RUN;
      RUN:     if (idx == LAST) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = '0;
    alu_l    = 1'b0;
    alu_c_in = 1'b0;
    ctl.busy = (state != IDLE);
    ctl.done = (state == DONE);
    if (state == RUN) begin
      alu_a    = a_q[{idx, 2'b00} +: 4];
      alu_b    = b_q[{idx, 2'b00} +: 4];
      alu_op   = op_q;
      alu_l    = l_q;
      // Pass 0 takes the external carry-in; later passes take the rippled carry flop.
      alu_c_in = l_q ? 1'b0 : ((idx == '0) ? cin_q : carry_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      op_q     <= '0;
      l_q      <= 1'b0;
      cin_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ctl.start) begin
            idx   <= '0;
            op_q  <= ctl.op;
            l_q   <= ctl.l;
            cin_q <= ctl.cin;
            a_q   <= ctl.a;
            b_q   <= ctl.b;
          end
        end
        RUN: begin
          result_q[{idx, 2'b00} +: 4] <= alu_r;
          carry_q <= l_q ? 1'b0 : alu_c_out;
          zero_q  <= (idx == '0) ? alu_zero : (zero_q & alu_zero);
          if (idx == LAST) sign_q <= alu_sign;
          else             idx    <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ctl.result = result_q;
  assign ctl.carry  = carry_q;
  assign ctl.zero   = zero_q;
  assign ctl.sign   = sign_q;
endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq (NIB=2) with a behavioural 4-bit ALU stand-in on the alu_* side.
module tb_alu_nibble_seq;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] alu_a, alu_b, alu_r;
  logic [1:0] alu_op;
  logic       alu_c_in, alu_l, alu_c_out, alu_zero, alu_sign;

  int unsigned total = 0;
  int unsigned passed = 0;

  alu_nibble_seq_if #(.NIB(2)) ctl ();

  alu_nibble_seq #(.NIB(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .ctl       (ctl.slave),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_c_in  (alu_c_in),
    .alu_op    (alu_op),
    .alu_l     (alu_l),
    .alu_r     (alu_r),
    .alu_c_out (alu_c_out),
    .alu_zero  (alu_zero),
    .alu_sign  (alu_sign)
  );

  always #5 clk = ~clk;

  // ALU stand-in: arithmetic 00 A+cin, 01 A+~B+cin, 10 A+B+cin, 11 ~A+B+cin; logic 00 AND, 01 OR, 10 XOR, 11 NOT A.
  logic [3:0] o1, o2;
  logic [4:0] s;
  always_comb begin
    o1 = alu_a;
    o2 = alu_b;
    case (alu_op)
      2'b00: o2 = 4'h0;
      2'b01: o2 = ~alu_b;
      2'b10: o2 = alu_b;
      default: o1 = ~alu_a;
    endcase
    s = {1'b0, o1} + {1'b0, o2} + {4'b0, alu_c_in};
    if (alu_l) begin
      case (alu_op)
        2'b00: alu_r = alu_a & alu_b;
        2'b01: alu_r = alu_a | alu_b;
        2'b10: alu_r = alu_a ^ alu_b;
        default: alu_r = ~alu_a;
      endcase
      alu_c_out = 1'b0;
    end else begin
      alu_r     = s[3:0];
      alu_c_out = s[4];
    end
    alu_zero = (alu_r == 4'h0);
    alu_sign = alu_r[3];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic [1:0] op;
    logic       l, cin;
    logic [7:0] r;
    logic       c, z, s, cin1;
  } vec_t;

  vec_t vecs[10];

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input logic l, input logic cin);
    ctl.a = a; ctl.b = b; ctl.op = op; ctl.l = l; ctl.cin = cin;
  endtask

  task automatic run_vec(input int unsigned i);
    int unsigned n, busy_cnt;
    logic got;
    logic [1:0] cins;
    vec_t v;
    string tag;
    v = vecs[i];
    tag = $sformatf("v%0d", i);
    drive(v.a, v.b, v.op, v.l, v.cin);
    ctl.start = 1'b1;
    @(posedge clk); #1;
    ctl.start = 1'b0;
    drive(8'hA5, 8'h5A, ~v.op, ~v.l, ~v.cin);
    n = 0; busy_cnt = 0; got = 1'b0; cins = '0;
    while (n < 10 && !got) begin
      if (ctl.busy) busy_cnt++;
      if (n < 2) cins[n] = alu_c_in;
      if (ctl.done) got = 1'b1;
      else begin @(posedge clk); #1; n++; end
    end
    chk({tag, " done_seen"}, 32'(got), 1);
    chk({tag, " latency_edges"}, n + 1, 3);
    chk({tag, " busy_cycles"}, busy_cnt, 3);
    chk({tag, " pass0_c_in"}, 32'(cins[0]), 32'(v.l ? 1'b0 : v.cin));
    chk({tag, " pass1_c_in"}, 32'(cins[1]), 32'(v.cin1));
    chk({tag, " result"}, 32'(ctl.result), 32'(v.r));
    chk({tag, " carry"}, 32'(ctl.carry), 32'(v.c));
    chk({tag, " zero"}, 32'(ctl.zero), 32'(v.z));
    chk({tag, " sign"}, 32'(ctl.sign), 32'(v.s));
    @(posedge clk); #1;
    chk({tag, " done_pulse_end"}, {30'b0, ctl.done, ctl.busy}, 0);
    chk({tag, " result_hold"}, 32'(ctl.result), 32'(v.r));
    chk({tag, " idle_alu_outs"}, {22'b0, alu_a, alu_b, alu_op}, 0);
  endtask

  initial begin
    vecs[0] = '{8'h3C, 8'h05, 2'b10, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 2'b10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h70, 8'h10, 2'b10, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'hF0, 8'h0F, 2'b00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hF0, 8'h0F, 2'b01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'hF0, 8'h0F, 2'b10, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'hF0, 8'h0F, 2'b11, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{8'h50, 8'h20, 2'b01, 1'b0, 1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{8'h0F, 8'h00, 2'b00, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{8'h12, 8'h34, 2'b10, 1'b0, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    ctl.start = 1'b0;
    drive(8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset result", 32'(ctl.result), 0);
    chk("reset flags", {28'b0, ctl.carry, ctl.zero, ctl.sign, ctl.busy}, 0);
    chk("reset done", 32'(ctl.done), 0);
    chk("reset alu outs", {21'b0, alu_a, alu_b, alu_op, alu_l}, 0);

    for (int i = 0; i < 10; i++) run_vec(i);

    // start held through RUN and DONE: ignored while busy, accepted in the following IDLE cycle
    drive(8'h3C, 8'h05, 2'b10, 1'b0, 1'b0);
    ctl.start = 1'b1;
    @(posedge clk); #1;
    drive(8'h01, 8'h01, 2'b10, 1'b0, 1'b0);
    chk("hold run0 busy/done", {30'b0, ctl.busy, ctl.done}, 2);
    @(posedge clk); #1;
    chk("hold run1 busy/done", {30'b0, ctl.busy, ctl.done}, 2);
    @(posedge clk); #1;
    chk("hold done pulse", {30'b0, ctl.busy, ctl.done}, 3);
    chk("hold first result", 32'(ctl.result), 32'h41);
    @(posedge clk); #1;
    chk("hold idle busy/done", {30'b0, ctl.busy, ctl.done}, 0);
    @(posedge clk); #1;
    ctl.start = 1'b0;
    chk("hold second accepted", {30'b0, ctl.busy, ctl.done}, 2);
    @(posedge clk); #1;
    chk("hold second run1", {30'b0, ctl.busy, ctl.done}, 2);
    @(posedge clk); #1;
    chk("hold second done", {30'b0, ctl.busy, ctl.done}, 3);
    chk("hold second result", 32'(ctl.result), 32'h02);
    @(posedge clk); #1;
    chk("hold no extra op", {30'b0, ctl.busy, ctl.done}, 0);

    // reset while RUN idx=1 aborts without a done pulse
    drive(8'hFF, 8'h01, 2'b10, 1'b0, 1'b0);
    ctl.start = 1'b1;
    @(posedge clk); #1;
    ctl.start = 1'b0;
    @(posedge clk); #1;
    chk("abort in run1", {30'b0, ctl.busy, ctl.done}, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort busy/done", {30'b0, ctl.busy, ctl.done}, 0);
    chk("abort result", 32'(ctl.result), 0);
    chk("abort flags", {29'b0, ctl.carry, ctl.zero, ctl.sign}, 0);
    chk("abort alu outs", {22'b0, alu_a, alu_b, alu_op}, 0);
    @(posedge clk); #1;
    chk("abort no late done", {30'b0, ctl.busy, ctl.done}, 0);
    run_vec(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
